mbtrain_tx_point_test: RTL and testbench
========================================

// Module: mbtrain_tx_point_test
// PURPOSE
// - TX-initiated D2C point test engine for MBTRAIN substates (VREFCAL, DATATRAINCENTER, ...); consumes o_pt_en/o_mainband_or_valtrain_test from the calibration FSMs and returns o_test_ack plus per-lane pass/fail.
// - Runs the sideband handshake (start, LFSR clear, result, end), drives the mainband pattern generator for a fixed burst and captures the partner's lane result.
// - Sits between the substate FSMs and the sideband encoder/decoder and pattern generator.
// PARAMETERS
// - PATTERN_CYCLES   default 128    clock cycles o_pattern_en is held per test
// - TIMEOUT_CYCLES   default 8000   max cycles waiting for any sideband response
// - LANES            default 16     mainband lane count (width of result)
// PORTS
// - clk                    in   1       clock
// - rst_n                  in   1       async reset, active low
// - i_pt_en                in   1       level request from substate FSM; drop aborts/ends test
// - i_mainband_or_valtrain in   1       0 = mainband data lanes, 1 = valid-lane pattern; sampled on IDLE exit
// - i_decoded_sideband_message in 4     decoded message from sideband RX
// - i_sideband_valid       in   1       qualifies i_decoded_sideband_message
// - i_sideband_data        in   LANES   payload carried with RESULT_RESP
// - i_busy_negedge_detected in  1       sideband TX finished a message
// - i_valid_rx             in   1       sideband RX owns the shared mux this cycle
// - o_sideband_message     out  4       message to sideband encoder
// - o_valid_tx             out  1       request to send o_sideband_message
// - o_pattern_en           out  1       pattern generator enable
// - o_pattern_sel          out  1       copy of latched i_mainband_or_valtrain
// - o_lfsr_clear           out  1       1-cycle pulse resetting local TX LFSR
// - o_lanes_result         out  LANES   captured result, 1 = lane passed
// - o_test_ack             out  1       level: test complete, held until i_pt_en low
// - o_timeout              out  1       level: response timeout, held until i_pt_en low
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0.
// - States: IDLE, START_REQ, LFSR_CLR_REQ, PATTERN, RESULT_REQ, END_REQ, DONE.
// - IDLE -> START_REQ when i_pt_en; latch i_mainband_or_valtrain; o_sideband_message<=START_REQ.
// - Each *_REQ state advances only on i_sideband_valid && message == matching *_RESP:
//   START_REQ->LFSR_CLR_REQ; LFSR_CLR_REQ->PATTERN (o_lfsr_clear pulses 1 cycle on this transition);
//   RESULT_REQ->END_REQ (o_lanes_result<=i_sideband_data same edge); END_REQ->DONE (o_test_ack<=1).
// - Non-matching or unqualified messages ignored (no state change).
// - o_sideband_message updated registered on the cycle the FSM enters each *_REQ state; 0 in DONE/IDLE.
// - o_valid_tx set 1 on the edge entering any *_REQ state; cleared on i_busy_negedge_detected && ~i_valid_rx; set has priority if both.
// - PATTERN: o_pattern_en=1 for exactly PATTERN_CYCLES cycles (counter 0..PATTERN_CYCLES-1), then ->RESULT_REQ, o_pattern_en<=0 same edge.
// - Timeout counter runs in every *_REQ state, clears on state change; reaching TIMEOUT_CYCLES-1 -> DONE with o_timeout=1, o_test_ack=1, o_lanes_result=0.
// - DONE -> IDLE when ~i_pt_en; o_test_ack, o_timeout cleared on that edge.
// - i_pt_en low in any non-IDLE state: -> IDLE next edge, all outputs except o_lanes_result cleared (result holds last value).
// - Response arriving same cycle as timeout expiry: response wins.
// - Counter widths: $clog2(max(PATTERN_CYCLES,TIMEOUT_CYCLES))+1, no wrap possible.
// STRUCTURE
// - Shared package mbtrain_pkg: 4-bit message codes START_REQ=1, START_RESP=2, LFSR_CLR_REQ=3, LFSR_CLR_RESP=4, RESULT_REQ=5, RESULT_RESP=6, END_REQ=7, END_RESP=8; state encoding constants.
// - One sub-module natural: mbtrain_sb_valid_ctrl (o_valid_tx set/clear handshake), reusable by all MBTRAIN FSMs.
// - Rest flat: next-state comb block, registered outputs, two counters.
// TESTING
// - Nominal: i_pt_en=1, responses 2,4 after 5 cycles each, RESULT_RESP data 16'hFFFF, END_RESP -> o_pattern_en high 128 cycles, o_lanes_result=FFFF, o_test_ack=1.
// - Valid handshake: busy negedge with i_valid_rx=1 -> o_valid_tx stays 1; next busy negedge with i_valid_rx=0 -> 0.
// - Timeout: never answer START_REQ -> o_timeout=o_test_ack=1 at cycle 8000, result 0; drop i_pt_en -> IDLE, flags 0.
// - Abort: drop i_pt_en mid-PATTERN (cycle 40) -> o_pattern_en=0 next edge, state IDLE, no ack.
// - Wrong message: send END_RESP while in START_REQ -> no transition; then START_RESP -> advances.
// - Async reset asserted in RESULT_REQ -> all outputs 0 immediately, IDLE after release; partial result 16'hA5A5 test records correct mask.

Source files
------------

// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: sideband message codes and point-test states.
// Imported by every MBTRAIN calibration/test FSM.
package mbtrain_pkg;

    typedef logic [3:0] sb_msg_t;

    localparam sb_msg_t MSG_NONE          = 4'd0;
    localparam sb_msg_t MSG_START_REQ     = 4'd1;
    localparam sb_msg_t MSG_START_RESP    = 4'd2;
    localparam sb_msg_t MSG_LFSR_CLR_REQ  = 4'd3;
    localparam sb_msg_t MSG_LFSR_CLR_RESP = 4'd4;
    localparam sb_msg_t MSG_RESULT_REQ    = 4'd5;
    localparam sb_msg_t MSG_RESULT_RESP   = 4'd6;
    localparam sb_msg_t MSG_END_REQ       = 4'd7;
    localparam sb_msg_t MSG_END_RESP      = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_START_REQ    = 3'd1,
        ST_LFSR_CLR_REQ = 3'd2,
        ST_PATTERN      = 3'd3,
        ST_RESULT_REQ   = 3'd4,
        ST_END_REQ      = 3'd5,
        ST_DONE         = 3'd6
    } pt_state_e;

    // Response code that lets a request state advance.
    function automatic sb_msg_t resp_msg(input pt_state_e s);
        sb_msg_t m;
        unique case (s)
            ST_START_REQ:    m = MSG_START_RESP;
            ST_LFSR_CLR_REQ: m = MSG_LFSR_CLR_RESP;
            ST_RESULT_REQ:   m = MSG_RESULT_RESP;
            ST_END_REQ:      m = MSG_END_RESP;
            default:         m = MSG_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mbtrain_sb_valid_ctrl.sv
// Sideband TX request flag: set when a new message is queued, cleared once
// the encoder finishes it while RX does not own the shared mux.
module mbtrain_sb_valid_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_set,
    input  logic i_busy_negedge_detected,
    input  logic i_valid_rx,
    output logic o_valid_tx
);

    logic valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (i_set) begin
            valid_q <= 1'b1;
        end else if (i_busy_negedge_detected && !i_valid_rx) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid_tx = valid_q;

endmodule

// File: rtl/mbtrain_tx_point_test.sv
// TX-initiated D2C point test: sideband start/clear/result/end handshake
// around a fixed-length mainband pattern burst.
module mbtrain_tx_point_test
    import mbtrain_pkg::*;
#(
    parameter int unsigned PATTERN_CYCLES = 128,
    parameter int unsigned TIMEOUT_CYCLES = 8000,
    parameter int unsigned LANES          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pt_en,
    input  logic             i_mainband_or_valtrain,
    input  logic [3:0]       i_decoded_sideband_message,
    input  logic             i_sideband_valid,
    input  logic [LANES-1:0] i_sideband_data,
    input  logic             i_busy_negedge_detected,
    input  logic             i_valid_rx,
    output logic [3:0]       o_sideband_message,
    output logic             o_valid_tx,
    output logic             o_pattern_en,
    output logic             o_pattern_sel,
    output logic             o_lfsr_clear,
    output logic [LANES-1:0] o_lanes_result,
    output logic             o_test_ack,
    output logic             o_timeout
);

    localparam int unsigned CMAX =
        (PATTERN_CYCLES > TIMEOUT_CYCLES) ? PATTERN_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] PAT_LAST = CW'(PATTERN_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    pt_state_e        state_q, state_d;
    sb_msg_t          msg_q, msg_d;
    logic             sel_q, sel_d;
    logic             pat_en_q, pat_en_d;
    logic             lfsr_clr_q, lfsr_clr_d;
    logic [LANES-1:0] result_q, result_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic [CW-1:0]    pat_cnt_q, pat_cnt_d;
    logic [CW-1:0]    to_cnt_q, to_cnt_d;

    logic resp_hit;
    logic to_hit;
    logic expire;
    logic vld_set;
    logic vld_flush;

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        sel_d      = sel_q;
        pat_en_d   = pat_en_q;
        lfsr_clr_d = 1'b0;
        result_d   = result_q;
        ack_d      = ack_q;
        timeout_d  = timeout_q;
        pat_cnt_d  = '0;
        to_cnt_d   = '0;
        expire     = 1'b0;
        vld_set    = 1'b0;
        vld_flush  = 1'b0;
        resp_hit   = i_sideband_valid &&
                     (i_decoded_sideband_message == resp_msg(state_q));
        to_hit     = (to_cnt_q == TO_LAST);

        if ((state_q != ST_IDLE) && !i_pt_en) begin
            // Abort or normal release: everything but the result drops.
            state_d   = ST_IDLE;
            msg_d     = MSG_NONE;
            sel_d     = 1'b0;
            pat_en_d  = 1'b0;
            ack_d     = 1'b0;
            timeout_d = 1'b0;
            vld_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_pt_en) begin
                        state_d = ST_START_REQ;
                        sel_d   = i_mainband_or_valtrain;
                        msg_d   = MSG_START_REQ;
                        vld_set = 1'b1;
                    end
                end
                ST_START_REQ: begin
                    if (resp_hit) begin
                        state_d = ST_LFSR_CLR_REQ;
                        msg_d   = MSG_LFSR_CLR_REQ;
                        vld_set = 1'b1;
                    end else if (to_hit) begin
                        expire = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_LFSR_CLR_REQ: begin
                    if (resp_hit) begin
                        state_d    = ST_PATTERN;
                        lfsr_clr_d = 1'b1;
                        pat_en_d   = 1'b1;
                    end else if (to_hit) begin
                        expire = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_PATTERN: begin
                    if (pat_cnt_q == PAT_LAST) begin
                        state_d  = ST_RESULT_REQ;
                        pat_en_d = 1'b0;
                        msg_d    = MSG_RESULT_REQ;
                        vld_set  = 1'b1;
                    end else begin
                        pat_cnt_d = pat_cnt_q + 1'b1;
                    end
                end
                ST_RESULT_REQ: begin
                    if (resp_hit) begin
                        state_d  = ST_END_REQ;
                        result_d = i_sideband_data;
                        msg_d    = MSG_END_REQ;
                        vld_set  = 1'b1;
                    end else if (to_hit) begin
                        expire = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_END_REQ: begin
                    if (resp_hit) begin
                        state_d = ST_DONE;
                        msg_d   = MSG_NONE;
                        ack_d   = 1'b1;
                    end else if (to_hit) begin
                        expire = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A partner that never answers ends the test with no lanes passed.
            if (expire) begin
                state_d   = ST_DONE;
                msg_d     = MSG_NONE;
                result_d  = '0;
                ack_d     = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            msg_q      <= MSG_NONE;
            sel_q      <= 1'b0;
            pat_en_q   <= 1'b0;
            lfsr_clr_q <= 1'b0;
            result_q   <= '0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            pat_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            sel_q      <= sel_d;
            pat_en_q   <= pat_en_d;
            lfsr_clr_q <= lfsr_clr_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            pat_cnt_q  <= pat_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    mbtrain_sb_valid_ctrl u_valid_ctrl (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_flush                 (vld_flush),
        .i_set                   (vld_set),
        .i_busy_negedge_detected (i_busy_negedge_detected),
        .i_valid_rx              (i_valid_rx),
        .o_valid_tx              (o_valid_tx)
    );

    assign o_sideband_message = msg_q;
    assign o_pattern_en       = pat_en_q;
    assign o_pattern_sel      = sel_q;
    assign o_lfsr_clear       = lfsr_clr_q;
    assign o_lanes_result     = result_q;
    assign o_test_ack         = ack_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_mbtrain_tx_point_test.sv
// Directed and randomized checks of the MBTRAIN TX point test engine.
module tb_mbtrain_tx_point_test;
    import mbtrain_pkg::*;

    localparam int PC = 128;
    localparam int TC = 8000;
    localparam int L  = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         pt_en = 1'b0;
    logic         sel_in = 1'b0;
    logic [3:0]   dec_msg = 4'd0;
    logic         sb_valid = 1'b0;
    logic [L-1:0] sb_data = '0;
    logic         busy = 1'b0;
    logic         vrx = 1'b0;

    logic [3:0]   o_msg;
    logic         o_valid_tx;
    logic         o_pattern_en;
    logic         o_pattern_sel;
    logic         o_lfsr_clear;
    logic [L-1:0] o_lanes_result;
    logic         o_test_ack;
    logic         o_timeout;

    int total = 0;
    int bad = 0;

    // Request sequence of one test; each response code is request + 1.
    logic [3:0] req_seq [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

    always #5 clk = ~clk;

    mbtrain_tx_point_test #(
        .PATTERN_CYCLES (PC),
        .TIMEOUT_CYCLES (TC),
        .LANES          (L)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_pt_en                    (pt_en),
        .i_mainband_or_valtrain     (sel_in),
        .i_decoded_sideband_message (dec_msg),
        .i_sideband_valid           (sb_valid),
        .i_sideband_data            (sb_data),
        .i_busy_negedge_detected    (busy),
        .i_valid_rx                 (vrx),
        .o_sideband_message         (o_msg),
        .o_valid_tx                 (o_valid_tx),
        .o_pattern_en               (o_pattern_en),
        .o_pattern_sel              (o_pattern_sel),
        .o_lfsr_clear               (o_lfsr_clear),
        .o_lanes_result             (o_lanes_result),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic [L-1:0] res);
        chk({tag, "_msg"}, 32'(o_msg), 32'd0);
        chk({tag, "_vtx"}, 32'(o_valid_tx), 32'd0);
        chk({tag, "_pat"}, 32'(o_pattern_en), 32'd0);
        chk({tag, "_sel"}, 32'(o_pattern_sel), 32'd0);
        chk({tag, "_lfsr"}, 32'(o_lfsr_clear), 32'd0);
        chk({tag, "_ack"}, 32'(o_test_ack), 32'd0);
        chk({tag, "_to"}, 32'(o_timeout), 32'd0);
        chk({tag, "_res"}, 32'(o_lanes_result), 32'(res));
    endtask

    task automatic send(input logic [3:0] m, input logic [L-1:0] d);
        sb_valid = 1'b1;
        dec_msg  = m;
        sb_data  = d;
        step();
        sb_valid = 1'b0;
        dec_msg  = 4'd0;
        sb_data  = '0;
    endtask

    // Traffic that must not move the FSM: foreign codes or unqualified match.
    task automatic noise(input logic [3:0] avoid, input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                sb_valid = 1'b0;
                dec_msg  = avoid;
            end else begin
                if (m == avoid) m = m + 4'd1;
                sb_valid = 1'b1;
                dec_msg  = m;
            end
            sb_data = L'($urandom);
            step();
        end
        sb_valid = 1'b0;
        dec_msg  = 4'd0;
        sb_data  = '0;
    endtask

    task automatic run_full(input logic sel, input logic [L-1:0] data,
                            input string tg);
        int n;
        pt_en  = 1'b1;
        sel_in = sel;
        step();
        sel_in = ~sel;
        for (int k = 0; k < 4; k++) begin
            chk({tg, "_req"}, 32'(o_msg), 32'(req_seq[k]));
            chk({tg, "_vtx"}, 32'(o_valid_tx), 32'd1);
            noise(req_seq[k] + 4'd1, $urandom_range(0, 8));
            chk({tg, "_hold"}, 32'(o_msg), 32'(req_seq[k]));
            send(req_seq[k] + 4'd1, data);
            if (k == 1) begin
                chk({tg, "_lfsr1"}, 32'(o_lfsr_clear), 32'd1);
                chk({tg, "_psel"}, 32'(o_pattern_sel), 32'(sel));
                n = 0;
                while (o_pattern_en === 1'b1 && n < PC + 50) begin
                    n++;
                    step();
                    if (n == 1) chk({tg, "_lfsr0"}, 32'(o_lfsr_clear), 32'd0);
                end
                chk({tg, "_patlen"}, 32'(n), 32'(PC));
            end
            if (k == 2) begin
                chk({tg, "_res"}, 32'(o_lanes_result), 32'(data));
            end
            if (k == 3) begin
                chk({tg, "_ack"}, 32'(o_test_ack), 32'd1);
                chk({tg, "_msg0"}, 32'(o_msg), 32'd0);
                chk({tg, "_to0"}, 32'(o_timeout), 32'd0);
            end
        end
        repeat ($urandom_range(1, 6)) step();
        chk({tg, "_ackhold"}, 32'(o_test_ack), 32'd1);
        pt_en = 1'b0;
        step();
        chk_quiet({tg, "_rel"}, data);
    endtask

    initial begin
        int n;
        logic [L-1:0] rd;

        #1 rst_n = 1'b0;
        #2;
        chk_quiet("reset", '0);
        step();
        step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk_quiet("post_reset", '0);

        run_full(1'b0, 16'hFFFF, "nominal");
        for (int t = 0; t < 3; t++) begin
            rd = L'($urandom);
            run_full(1'($urandom_range(0, 1)), rd, "rand");
        end

        // Valid handshake, set priority and wrong-message rejection.
        pt_en = 1'b1;
        step();
        chk("hs_set", 32'(o_valid_tx), 32'd1);
        busy = 1'b1;
        vrx  = 1'b1;
        step();
        busy = 1'b0;
        vrx  = 1'b0;
        chk("hs_rx_owns", 32'(o_valid_tx), 32'd1);
        busy = 1'b1;
        step();
        busy = 1'b0;
        chk("hs_clear", 32'(o_valid_tx), 32'd0);
        send(MSG_END_RESP, '0);
        chk("wrong_msg", 32'(o_msg), 32'(MSG_START_REQ));
        busy = 1'b1;
        send(MSG_START_RESP, '0);
        busy = 1'b0;
        chk("hs_set_prio", 32'(o_valid_tx), 32'd1);
        chk("wrong_then_ok", 32'(o_msg), 32'(MSG_LFSR_CLR_REQ));
        pt_en = 1'b0;
        step();
        chk("hs_abort_vtx", 32'(o_valid_tx), 32'd0);

        // Unanswered START_REQ times out.
        pt_en = 1'b1;
        step();
        n = 0;
        while (o_timeout !== 1'b1 && n < TC + 100) begin
            step();
            n++;
        end
        chk("to_cycles", 32'(n), 32'(TC));
        chk("to_ack", 32'(o_test_ack), 32'd1);
        chk("to_res", 32'(o_lanes_result), 32'd0);
        pt_en = 1'b0;
        step();
        chk_quiet("to_rel", '0);

        // Response landing on the expiry edge wins.
        pt_en = 1'b1;
        step();
        repeat (TC - 1) step();
        send(MSG_START_RESP, '0);
        chk("race_to", 32'(o_timeout), 32'd0);
        chk("race_adv", 32'(o_msg), 32'(MSG_LFSR_CLR_REQ));
        pt_en = 1'b0;
        step();

        // Abort mid pattern.
        pt_en = 1'b1;
        step();
        send(MSG_START_RESP, '0);
        send(MSG_LFSR_CLR_RESP, '0);
        repeat (40) step();
        chk("abort_pat_on", 32'(o_pattern_en), 32'd1);
        pt_en = 1'b0;
        step();
        chk_quiet("abort", '0);
        repeat (3) step();
        chk("abort_idle", 32'(o_msg), 32'd0);

        // Async reset while waiting for RESULT_RESP.
        pt_en = 1'b1;
        step();
        send(MSG_START_RESP, '0);
        send(MSG_LFSR_CLR_RESP, '0);
        n = 0;
        while (o_pattern_en === 1'b1 && n < PC + 50) begin
            step();
            n++;
        end
        chk("rst_in_result", 32'(o_msg), 32'(MSG_RESULT_REQ));
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("async_rst", '0);
        pt_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk_quiet("rst_idle", '0);

        run_full(1'b1, 16'hA5A5, "partial");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
